// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: one load/store in flight, byte-lane stores, range/alignment error flag.
// Latency: request accepted at edge e0 commits at edge e0+LATENCY; rsp_valid is visible from the following cycle.
// Backpressure: req_ready is high only in IDLE; a response is held stable until rsp_ready, then IDLE resumes.
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-low reset
//   req_valid/req_ready           request handshake (req_we, req_addr, req_wdata, req_be)
//   rsp_valid/rsp_ready           response handshake (rsp_rdata, rsp_err)
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [29:0]   DEPTH_W  = 30'(DEPTH_WORDS);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request captured at acceptance; the error flag is resolved up front so the
    // commit edge only has to pick between memory access and error response.
    typedef struct packed {
        logic          we;
        logic          err;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } req_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    req_t          lat;
    logic          accept;
    logic          commit;
    logic          req_err;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept  = req_valid && req_ready;
    assign commit  = (state == WAIT) && (cnt == '0);
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_W);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state == IDLE);
    end

    // Latency countdown: loaded with LATENCY-1 so the commit lands on edge e0+LATENCY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Request capture is pure datapath; it only matters once the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat.we    <= req_we;
            lat.err   <= req_err;
            lat.idx   <= req_addr[AW+1:2];
            lat.wdata <= req_wdata;
            lat.be    <= req_be;
        end
    end

    // Storage is never reset; a store dropped by reset must not reach it,
    // hence the explicit reset qualifier on the write.
    always_ff @(posedge clk) begin
        if (reset && commit && lat.we && !lat.err) begin
            for (int i = 0; i < 4; i++) begin
                if (lat.be[i]) begin
                    mem[lat.idx][8*i +: 8] <= lat.wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: set on commit, rsp_valid cleared on handshake,
    // data/err held until the next commit or reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= lat.err;
            rsp_rdata <= (lat.err || lat.we) ? 32'd0 : mem[lat.idx];
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    bit          rand_rdy  = 1'b0;
    bit          rdy_force = 1'b1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: whole-transaction semantics applied at acceptance.
    task automatic model_accept(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   idx;
        bit   err;
        err     = ((addr % 4) != 0) || ((addr >> 2) >= 32'(DEPTH));
        e.err   = err;
        e.rdata = 32'd0;
        e.due   = cyc + 1 + LAT;
        if (!err) begin
            idx = int'(addr >> 2);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = ref_mem[idx];
            end
        end
        sb.push_back(e);
    endtask

    // Called in the phase just after a rising edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit model, input bit hold);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 300);
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout actual=req_ready_low required=accept addr=%h", addr);
            req_valid = 1'b0;
            return;
        end
        if (model) model_accept(we, addr, wdata, be);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((!req_ready || rsp_valid || sb.size() != 0) && n < 500);
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout actual=pending%0d required=pending0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Single driver for rsp_ready: random in the soak phase, directed otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: latency on rise, stability while stalled, data on handshake.
    bit          mon_pv = 1'b0;
    logic [31:0] mon_pd;
    logic        mon_pe;
    exp_t        mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (!mon_pv) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=rsp_valid1 required=rsp_valid0 cyc=%0d", cyc);
                    end else begin
                        chk("rsp_latency", 32'(cyc), 32'(sb[0].due));
                    end
                end else begin
                    chk("rsp_hold_rdata", rsp_rdata, mon_pd);
                    chk("rsp_hold_err", 32'(rsp_err), 32'(mon_pe));
                end
                if (rsp_ready && sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
            end
            mon_pv = (rsp_valid === 1'b1);
            mon_pd = rsp_rdata;
            mon_pe = rsp_err;
        end
    end

    initial begin
        int          n;
        int          r;
        logic        we;
        logic [31:0] addr;

        // Reset held for two edges with a request presented.
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h5555_5555;
        req_be    = 4'hF;
        repeat (2) begin
            @(negedge clk);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid_post", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0);

        // Store/load and byte-lane merges.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b1, 1'b0);
        wait_idle();

        // Backpressure: response stalled 5 cycles with a request still held.
        rdy_force = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_AAEF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_req_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Error cases.
        issue(1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h100, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        wait_idle();

        // Reset one edge after accepting a store: the store must be dropped.
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
        wait_idle();

        // Randomised soak with random response backpressure.
        rand_rdy = 1'b1;
        repeat (200) begin
            r  = int'($urandom_range(0, 9));
            we = 1'($urandom_range(0, 1));
            if (r < 7)       addr = $urandom_range(0, 63) << 2;
            else if (r == 7) addr = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
            else if (r == 8) addr = $urandom_range(64, 4095) << 2;
            else             addr = $urandom;
            issue(we, addr, $urandom, 4'($urandom), 1'b1, 1'b0);
        end
        wait_idle();
        rand_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
